// File: rtl/char_pkg.sv
`default_nettype none
// ============================================================
// char_pkg: sprite, facing, attack-FSM and stage encodings. Rev 1.0
// ============================================================
package char_pkg;

  typedef enum logic [3:0] {
    FACE_FRONT_STAND  = 4'h0,
    FACE_FRONT_L      = 4'h1,
    FACE_FRONT_R      = 4'h2,
    FACE_BACK_STAND   = 4'h3,
    FACE_BACK_L       = 4'h4,
    FACE_BACK_R       = 4'h5,
    FACE_LEFT_STAND   = 4'h6,
    FACE_LEFT_WALK    = 4'h7,
    FACE_RIGHT_STAND  = 4'h8,
    FACE_RIGHT_WALK   = 4'h9,
    FACE_FRONT_ATTACK = 4'hA,
    FACE_BACK_ATTACK  = 4'hB,
    FACE_LEFT_ATTACK  = 4'hC,
    FACE_RIGHT_ATTACK = 4'hD,
    EMPTY             = 4'hF
  } sprite_t;

  typedef enum logic [1:0] {
    FACING_BACK  = 2'd0,
    FACING_FRONT = 2'd1,
    FACING_LEFT  = 2'd2,
    FACING_RIGHT = 2'd3
  } facing_t;

  typedef enum logic [1:0] {
    ATK_IDLE     = 2'd0,
    ATK_ATTACK   = 2'd1,
    ATK_COOLDOWN = 2'd2
  } atk_state_t;

  localparam logic [3:0] STAGE_TITLE = 4'h0;
  localparam logic [3:0] STAGE_OVER  = 4'hF;

  function automatic sprite_t stand_code(input facing_t f);
    sprite_t s;
    case (f)
      FACING_BACK:  s = FACE_BACK_STAND;
      FACING_FRONT: s = FACE_FRONT_STAND;
      FACING_LEFT:  s = FACE_LEFT_STAND;
      default:      s = FACE_RIGHT_STAND;
    endcase
    return s;
  endfunction

  function automatic sprite_t attack_code(input facing_t f);
    sprite_t s;
    case (f)
      FACING_BACK:  s = FACE_BACK_ATTACK;
      FACING_FRONT: s = FACE_FRONT_ATTACK;
      FACING_LEFT:  s = FACE_LEFT_ATTACK;
      default:      s = FACE_RIGHT_ATTACK;
    endcase
    return s;
  endfunction

  // Alternate between the two walk frames of the held direction
  function automatic sprite_t walk_code(input facing_t f, input sprite_t cur);
    sprite_t s;
    case (f)
      FACING_BACK:  s = (cur == FACE_BACK_L)     ? FACE_BACK_R      : FACE_BACK_L;
      FACING_FRONT: s = (cur == FACE_FRONT_L)    ? FACE_FRONT_R     : FACE_FRONT_L;
      FACING_LEFT:  s = (cur == FACE_LEFT_WALK)  ? FACE_LEFT_STAND  : FACE_LEFT_WALK;
      default:      s = (cur == FACE_RIGHT_WALK) ? FACE_RIGHT_STAND : FACE_RIGHT_WALK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/char_attack_timer.sv
`default_nettype none
// ============================================================
// char_attack_timer: IDLE -> ATTACK -> COOLDOWN -> IDLE timer. Rev 1.0
// ============================================================
module char_attack_timer
  import char_pkg::*;
#(
  parameter int ATK_LEN = 16,
  parameter int ATK_CD  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic start_i,
  output logic attacking_o,
  output logic busy_o
);

  localparam int MAX_LEN = (ATK_LEN > ATK_CD) ? ATK_LEN : ATK_CD;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  atk_state_t       st_q;
  logic [CNT_W-1:0] cnt_q;
  logic             attacking_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      st_q        <= ATK_IDLE;
      cnt_q       <= '0;
      attacking_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (st_q)
        ATK_IDLE: begin
          if (start_i) begin
            st_q        <= ATK_ATTACK;
            cnt_q       <= CNT_W'(ATK_LEN - 1);
            attacking_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ATK_ATTACK: begin
          if (cnt_q == '0) begin
            st_q        <= ATK_COOLDOWN;
            cnt_q       <= CNT_W'(ATK_CD - 1);
            attacking_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ATK_COOLDOWN: begin
          if (cnt_q == '0) begin
            st_q   <= ATK_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          st_q        <= ATK_IDLE;
          cnt_q       <= '0;
          attacking_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign attacking_o = attacking_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: rtl/player_controller.sv
`default_nettype none
// ============================================================
// player_controller: keys to bounded position, sprite, lives, i-frames. Rev 1.0
// ============================================================
module player_controller
  import char_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int H_START    = 150,
  parameter int V_START    = 110,
  parameter int H_MIN      = 20,
  parameter int H_MAX      = 620,
  parameter int V_MIN      = 0,
  parameter int V_MAX      = 460,
  parameter int STEP       = 1,
  parameter int ANIM_DIV   = 8,
  parameter int LIVES_INIT = 3,
  parameter int LIVES_W    = 4,
  parameter int IFRAME     = 100,
  parameter int IFRAME_W   = 8,
  parameter int ATK_LEN    = 16,
  parameter int ATK_CD     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_w,
  input  logic               key_a,
  input  logic               key_s,
  input  logic               key_d,
  input  logic               key_space,
  input  logic [3:0]         stage,
  input  logic               is_attacked,
  input  logic [3:0]         wall_collision,
  output logic [POS_W-1:0]   pos_h,
  output logic [POS_W-1:0]   pos_v,
  output logic [3:0]         state,
  output logic [1:0]         facing,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               attacking,
  output logic               dead
);

  localparam int ANIM_W = $clog2(ANIM_DIV);

  logic [POS_W-1:0]    pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  sprite_t             state_q, state_d;
  facing_t             facing_q, facing_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [IFRAME_W-1:0] iframe_q, iframe_d;
  logic [ANIM_W-1:0]   anim_q, anim_d;
  logic                invuln_q, invuln_d, dead_q, dead_d;
  logic                play, any_key, hit, atk_start, atk_busy, atk_active;
  logic [POS_W:0]      h_up, h_dn, v_up, v_dn;

  // One extra bit so that stepping below zero wraps high and fails the upper bound
  function automatic logic in_bounds(input logic [POS_W:0] p, input int lo, input int hi);
    return (p >= (POS_W+1)'(lo)) && (p <= (POS_W+1)'(hi));
  endfunction

  assign play      = (stage != STAGE_TITLE) && (stage != STAGE_OVER);
  assign any_key   = key_w | key_s | key_a | key_d;
  assign atk_start = play && key_space && !dead_q && !atk_busy;
  assign h_up      = {1'b0, pos_h_q} + (POS_W+1)'(STEP);
  assign h_dn      = {1'b0, pos_h_q} - (POS_W+1)'(STEP);
  assign v_up      = {1'b0, pos_v_q} + (POS_W+1)'(STEP);
  assign v_dn      = {1'b0, pos_v_q} - (POS_W+1)'(STEP);

  char_attack_timer #(
    .ATK_LEN (ATK_LEN),
    .ATK_CD  (ATK_CD)
  ) u_atk (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (!play),
    .start_i     (atk_start),
    .attacking_o (atk_active),
    .busy_o      (atk_busy)
  );

  always_comb begin
    facing_d = facing_q;
    if (play && !dead_q) begin
      if      (key_w) facing_d = FACING_BACK;
      else if (key_s) facing_d = FACING_FRONT;
      else if (key_a) facing_d = FACING_LEFT;
      else if (key_d) facing_d = FACING_RIGHT;
    end

    pos_h_d = pos_h_q;
    pos_v_d = pos_v_q;
    if (play && !dead_q && !atk_busy) begin
      if (key_w) begin
        if (!wall_collision[2] && in_bounds(v_up, V_MIN, V_MAX)) pos_v_d = v_up[POS_W-1:0];
      end else if (key_s) begin
        if (!wall_collision[3] && in_bounds(v_dn, V_MIN, V_MAX)) pos_v_d = v_dn[POS_W-1:0];
      end else if (key_a) begin
        if (!wall_collision[1] && in_bounds(h_up, H_MIN, H_MAX)) pos_h_d = h_up[POS_W-1:0];
      end else if (key_d) begin
        if (!wall_collision[0] && in_bounds(h_dn, H_MIN, H_MAX)) pos_h_d = h_dn[POS_W-1:0];
      end
    end

    hit      = is_attacked && (iframe_q == '0) && (lives_q != '0);
    lives_d  = hit ? lives_q - LIVES_W'(1) : lives_q;
    iframe_d = hit ? IFRAME_W'(IFRAME)
             : (iframe_q != '0) ? iframe_q - IFRAME_W'(1) : '0;
    dead_d   = play && (lives_d == '0);
    anim_d   = (anim_q == ANIM_W'(ANIM_DIV - 1)) ? '0 : anim_q + ANIM_W'(1);

    // Sprite only advances on animation ticks; attack entry is the one exception
    state_d = state_q;
    if (dead_d) begin
      state_d = EMPTY;
    end else if (anim_q == '0) begin
      if (iframe_q != '0 && state_q != EMPTY) state_d = EMPTY;
      else if (atk_active)                    state_d = attack_code(facing_d);
      else if (any_key)                       state_d = walk_code(facing_d, state_q);
      else                                    state_d = stand_code(facing_d);
    end else if (atk_start) begin
      state_d = attack_code(facing_d);
    end

    invuln_d = (iframe_d != '0);

    if (!play) begin
      pos_h_d  = POS_W'(H_START);
      pos_v_d  = POS_W'(V_START);
      state_d  = EMPTY;
      facing_d = FACING_BACK;
      lives_d  = (stage == STAGE_TITLE) ? LIVES_W'(LIVES_INIT) : '0;
      iframe_d = '0;
      anim_d   = '0;
      invuln_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_h_q  <= POS_W'(H_START);
      pos_v_q  <= POS_W'(V_START);
      state_q  <= EMPTY;
      facing_q <= FACING_BACK;
      lives_q  <= LIVES_W'(LIVES_INIT);
      iframe_q <= '0;
      anim_q   <= '0;
      invuln_q <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      pos_h_q  <= pos_h_d;
      pos_v_q  <= pos_v_d;
      state_q  <= state_d;
      facing_q <= facing_d;
      lives_q  <= lives_d;
      iframe_q <= iframe_d;
      anim_q   <= anim_d;
      invuln_q <= invuln_d;
      dead_q   <= dead_d;
    end
  end

  assign pos_h     = pos_h_q;
  assign pos_v     = pos_v_q;
  assign state     = state_q;
  assign facing    = facing_q;
  assign lives     = lives_q;
  assign invuln    = invuln_q;
  assign attacking = atk_active;
  assign dead      = dead_q;

endmodule
`default_nettype wire

// File: tb/tb_player_controller.sv
`default_nettype none
// ============================================================
// tb_player_controller: directed stimulus against a cycle-level reference model. Rev 1.0
// ============================================================
module tb_player_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_w = 1'b0, key_a = 1'b0, key_s = 1'b0, key_d = 1'b0, key_space = 1'b0;
  logic [3:0] stage = 4'h0;
  logic       is_attacked = 1'b0;
  logic [3:0] wall = 4'h0;

  logic [9:0] pos_h, pos_v;
  logic [3:0] state;
  logic [1:0] facing;
  logic [3:0] lives;
  logic       invuln, attacking, dead;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  player_controller dut (
    .clk            (clk),
    .rst            (rst),
    .key_w          (key_w),
    .key_a          (key_a),
    .key_s          (key_s),
    .key_d          (key_d),
    .key_space      (key_space),
    .stage          (stage),
    .is_attacked    (is_attacked),
    .wall_collision (wall),
    .pos_h          (pos_h),
    .pos_v          (pos_v),
    .state          (state),
    .facing         (facing),
    .lives          (lives),
    .invuln         (invuln),
    .attacking      (attacking),
    .dead           (dead)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sprite tables indexed by facing: back, front, left, right
  int stand_t[4] = '{3, 0, 6, 8};
  int atk_t_c[4] = '{11, 10, 12, 13};
  int walk1[4]   = '{4, 1, 7, 9};
  int walk2[4]   = '{5, 2, 6, 8};

  int m_h, m_v, m_state, m_face, m_lives, m_if, m_anim, m_dead, m_inv, m_att;
  int m_valid = 0;

  // Reference model: the attack is tracked by the edge index at which it began
  initial begin
    int e, atk_t, k, nface, nh, nv, nl, nif, nstate;
    bit cur_att, cur_busy, entry, hit, tick, ndead;
    e = 0;
    atk_t = -1000;
    forever begin
      @(negedge clk);
      if (m_valid != 0) begin
        check("pos_h", pos_h, m_h);
        check("pos_v", pos_v, m_v);
        check("state", state, m_state);
        check("facing", facing, m_face);
        check("lives", lives, m_lives);
        check("invuln", invuln, m_inv);
        check("attacking", attacking, m_att);
        check("dead", dead, m_dead);
      end
      if (rst || stage == 4'h0 || stage == 4'hF) begin
        m_h = 150; m_v = 110; m_state = 15; m_face = 0;
        m_lives = (rst || stage == 4'h0) ? 3 : 0;
        m_if = 0; m_anim = 0; m_dead = 0; atk_t = -1000;
      end else begin
        cur_att  = (e - atk_t >= 1) && (e - atk_t <= 16);
        cur_busy = (e - atk_t >= 1) && (e - atk_t <= 48);
        k = key_w ? 0 : key_s ? 1 : key_a ? 2 : key_d ? 3 : -1;
        entry = !cur_busy && key_space && (m_dead == 0);
        nface = m_face;
        if (m_dead == 0 && k >= 0) nface = k;
        nh = m_h; nv = m_v;
        if (m_dead == 0 && !cur_busy) begin
          case (k)
            0: if (!wall[2] && m_v + 1 <= 460) nv = m_v + 1;
            1: if (!wall[3] && m_v - 1 >= 0)   nv = m_v - 1;
            2: if (!wall[1] && m_h + 1 <= 620) nh = m_h + 1;
            3: if (!wall[0] && m_h - 1 >= 20)  nh = m_h - 1;
            default: ;
          endcase
        end
        hit   = is_attacked && m_if == 0 && m_lives > 0;
        nl    = hit ? m_lives - 1 : m_lives;
        nif   = hit ? 100 : (m_if > 0 ? m_if - 1 : 0);
        ndead = (nl == 0);
        tick  = (m_anim == 0);
        nstate = m_state;
        if (ndead) nstate = 15;
        else if (tick) begin
          if (m_if != 0 && m_state != 15) nstate = 15;
          else if (cur_att)               nstate = atk_t_c[nface];
          else if (k >= 0)                nstate = (m_state == walk1[nface]) ? walk2[nface] : walk1[nface];
          else                            nstate = stand_t[nface];
        end else if (entry) nstate = atk_t_c[nface];
        if (entry) atk_t = e;
        m_h = nh; m_v = nv; m_face = nface; m_lives = nl; m_if = nif;
        m_dead = ndead ? 1 : 0; m_state = nstate; m_anim = (m_anim + 1) % 8;
      end
      m_att = ((e + 1 - atk_t >= 1) && (e + 1 - atk_t <= 16)) ? 1 : 0;
      m_inv = (m_if != 0) ? 1 : 0;
      e++;
      m_valid = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    step(2);
    check("reset pos_h", pos_h, 150);
    check("reset pos_v", pos_v, 110);
    check("reset state", state, 15);
    check("reset lives", lives, 3);
    rst = 1'b0;

    stage = 4'h1; key_a = 1'b1; step(10);
    check("walk A pos_h", pos_h, 160);
    check("walk A pos_v", pos_v, 110);
    check("walk A facing", facing, 2);
    check("walk A state", state, 6);
    key_a = 1'b0;

    key_d = 1'b1; step(143); key_d = 1'b0;
    check("H_MIN clamp", pos_h, 20);
    key_s = 1'b1; step(115); key_s = 1'b0;
    check("V_MIN clamp", pos_v, 0);
    key_w = 1'b1; step(110);
    check("walk W back", pos_v, 110);
    wall = 4'b0100; step(5); wall = 4'h0;
    check("wall W", pos_v, 110);

    key_space = 1'b1; step(1); key_space = 1'b0;
    check("attack start", attacking, 1);
    check("attack move", pos_v, 111);
    step(15);
    check("attack last", attacking, 1);
    step(1);
    check("attack end", attacking, 0);
    step(32);
    check("cooldown freeze", pos_v, 111);
    step(1);
    check("move after cd", pos_v, 112);
    key_w = 1'b0; step(10);

    key_space = 1'b1; step(49);
    check("held space idle", attacking, 0);
    step(1);
    check("held space retrig", attacking, 1);
    key_space = 1'b0; step(60);

    is_attacked = 1'b1; step(1);
    check("hit1 lives", lives, 2);
    check("hit1 invuln", invuln, 1);
    step(100);
    check("iframe hold", lives, 2);
    step(1);
    check("hit2 lives", lives, 1);
    step(101);
    check("hit3 lives", lives, 0);
    check("hit3 dead", dead, 1);
    step(47); is_attacked = 1'b0;
    key_a = 1'b1; key_space = 1'b1; step(5); key_a = 1'b0; key_space = 1'b0;
    check("dead frozen", pos_h, 20);
    check("dead state", state, 15);
    check("dead no atk", attacking, 0);

    stage = 4'h0; step(1);
    check("title lives", lives, 3);
    check("title pos_h", pos_h, 150);
    check("title dead", dead, 0);

    stage = 4'h1; key_space = 1'b1; is_attacked = 1'b1; step(1);
    key_space = 1'b0; is_attacked = 1'b0;
    check("hit+atk att", attacking, 1);
    check("hit+atk lives", lives, 2);
    step(3);
    stage = 4'hF; step(1);
    check("over att", attacking, 0);
    check("over lives", lives, 0);
    check("over state", state, 15);
    check("over invuln", invuln, 0);

    stage = 4'h1; rst = 1'b1; step(1);
    check("rst dominates", lives, 3);
    rst = 1'b0; key_s = 1'b1; step(20); key_s = 1'b0; step(4);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_controller.md
# player_controller

Parametrised player-character controller for the top-down game datapath. It turns debounced W/A/S/D/SPACE key levels into a bounded position, a sprite state code, lives and an invulnerability window. Over the single-character controller it adds configurable bounds, speed, animation rate, lives and i-frames, plus a timed attack/cooldown FSM, a death lock-out and explicit status flags. It sits between the keyboard decoder and the sprite renderer / enemy collision logic.

## Interface
- POS_W, 10, width of pos_h/pos_v
- H_START, 150; V_START, 110: spawn position
- H_MIN, 20; H_MAX, 620; V_MIN, 0; V_MAX, 460: inclusive position bounds
- STEP, 1: pixels moved per cycle
- ANIM_DIV, 8: cycles per animation tick (≥2)
- LIVES_INIT, 3; LIVES_W, 4: starting lives and counter width
- IFRAME, 100; IFRAME_W, 8: invulnerability cycles after a hit
- ATK_LEN, 16; ATK_CD, 32: attack active cycles and cooldown cycles (each ≥1)
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- key_w, key_a, key_s, key_d, key_space  in  1 each  key held levels
- stage  in  4  game stage; 0 = title, 0xF = game over, others = play
- is_attacked  in  1  enemy contact this cycle
- wall_collision  in  4  blocked directions: bit0 D, bit1 A, bit2 W, bit3 S
- pos_h, pos_v  out  POS_W  position
- state  out  4  sprite code (package encoding, EMPTY = 0xF)
- facing  out  2  0 back(W), 1 front(S), 2 left(A), 3 right(D)
- lives  out  LIVES_W  remaining lives
- invuln  out  1  i-frame counter nonzero
- attacking  out  1  attack FSM in ATTACK
- dead  out  1  lives == 0 during play stage

## Operation
- Reset values: pos = (H_START, V_START), state EMPTY, facing 0, lives LIVES_INIT, invuln/attacking/dead 0, all counters 0, attack FSM IDLE.
- Inactive stage (0 or 0xF): the same values as reset are forced every cycle, except lives: LIVES_INIT in stage 0, 0 in stage 0xF. dead is 0 in both.
- Key priority W > S > A > D; facing follows the winning key; no key leaves facing unchanged.
- Movement: W pos_v+STEP, S pos_v−STEP, A pos_h+STEP, D pos_h−STEP.
- A step is suppressed if:
  - the matching wall_collision bit is set, or
  - the result would leave [MIN, MAX] (no partial step; compare in POS_W+1 bits), or
  - the attack FSM ≠ IDLE, or
  - dead.
- Attack FSM states IDLE → ATTACK (ATK_LEN cycles) → COOLDOWN (ATK_CD cycles) → IDLE.
  - Entry needs key_space=1 in IDLE and not dead.
  - Held SPACE re-triggers only on return to IDLE.
- Hit: is_attacked && iframe==0 && lives>0 → lives−1 and iframe←IFRAME. Otherwise iframe decrements to 0. Lives saturate at 0.
- Animation counter runs 0..ANIM_DIV−1. On tick (counter==0):
  - if iframe≠0 and state≠EMPTY → EMPTY (blink);
  - else walk-toggle per key (back L/R, front L/R, left walk/stand, right walk/stand), or facing stand with no key.
  - While attacking, the attack sprite for the current facing replaces the walk/stand code.
- Non-tick cycles hold state, except the IDLE→ATTACK edge, which loads the attack sprite immediately.
- dead forces state EMPTY and freezes pos.

## Timing
- All outputs registered. Key → pos change: 1 cycle. is_attacked → lives/invuln: 1 cycle.
- SPACE at edge t → attacking=1 from t+1 for exactly ATK_LEN cycles, then ATK_CD cycles of cooldown.
- Simultaneous hit and attack start: both take effect; an attack in progress continues through the hit.
- Stage leaving play mid-attack or mid-iframe: everything clears on the next edge.
- rst dominates stage.

## Structure
- Package char_pkg holds the sprite codes (FACE_FRONT_STAND=0 … FACE_RIGHT_ATTACK=0xD, EMPTY=0xF), facing codes, and STAGE_TITLE=0 / STAGE_OVER=0xF.
- Sub-module char_attack_timer holds the IDLE/ATTACK/COOLDOWN FSM and its down-counter, with outputs attacking and busy.

## Test plan
- Reset, stage=1, hold key_a 10 cycles → pos_h=160, pos_v=110, facing=2; state toggles left walk/stand every 8 cycles.
- Hold key_d from pos_h=22 for 5 cycles → pos_h stops at 20. Hold key_w with wall_collision=4'b0100 → pos_v stays 110.
- Pulse key_space while holding key_w → attacking high for 16 cycles, pos_v constant for 48 cycles; SPACE held throughout → second attack starts at cycle 49.
- is_attacked held 250 cycles → lives 3→2 at cycle 1, 2→1 at cycle 102, 1→0 at cycle 203; invuln high during each window; state blinks EMPTY on alternate ticks.
- With lives=0 → dead=1, keys ignored, state=EMPTY. Stage→0 → lives=3, pos=(150,110), dead=0.
- Stage→0xF mid-attack → next cycle attacking=0, lives=0, state=EMPTY.
